rf_access_sched: RTL and testbench

RF_ACCESS_SCHED -- requirements
Module: rf_access_sched

---
 rtl/rf_access_sched.sv | 160 ++++++++++++++++
 tb/tb_rf_access_sched.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_access_sched.sv
// rf_access_sched: arbitrates two requesters (core, debug/aux) onto one register-file port.
// Latency: req in IDLE at cycle N -> gnt/we/mux_sel/segs at N+1 -> rd_valid/rd_owner at N+2 (reads).
// Backpressure: requesters hold req/wr/sel/seg until gnt; requests are sampled only in IDLE.
// Build option: define RF_SCHED_RR_EN for round-robin arbitration; default is fixed priority (req0 wins).
module rf_access_sched (
    input  logic       clk,
    input  logic       clr,
    input  logic       req0,
    input  logic       req1,
    input  logic       wr0,
    input  logic       wr1,
    input  logic [2:0] sel0,
    input  logic [2:0] sel1,
    input  logic [2:0] wseg0,
    input  logic [2:0] wseg1,
    input  logic [2:0] rseg0,
    input  logic [2:0] rseg1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       we,
    output logic [2:0] mux_sel,
    output logic [2:0] write_seg,
    output logic [2:0] read_seg,
    output logic       rd_valid,
    output logic       rd_owner,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_RDW  = 2'd2
    } state_t;

    // Mux code the register file treats as "write nothing".
    localparam logic [2:0] SEL_NOP = 3'b111;

    state_t     state_q, state_d;
    logic       gnt0_q, gnt0_d;
    logic       gnt1_q, gnt1_d;
    logic       we_q, we_d;
    logic [2:0] mux_sel_q, mux_sel_d;
    logic [2:0] write_seg_q, write_seg_d;
    logic [2:0] read_seg_q, read_seg_d;
    logic       rd_valid_q, rd_valid_d;
    logic       rd_owner_q, rd_owner_d;
    logic       busy_q, busy_d;
    logic       win1;

`ifdef RF_SCHED_RR_EN
    // Index of the requester that wins the next tie (the one not granted last).
    logic       ptr_q, ptr_d;

    // Round-robin winner select: a tie goes to the requester the pointer names.
    always_comb begin
        win1 = req1 & (~req0 | ptr_q);
    end
`else
    // Fixed-priority winner select: requester 0 always wins a tie.
    always_comb begin
        win1 = req1 & ~req0;
    end
`endif

    // Next-state and next-output computation; outputs default to their idle values.
    // In ACC the output flops themselves hold the captured request, so we_q is the
    // captured wr and gnt1_q is the winner index.
    always_comb begin
        state_d     = state_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        we_d        = 1'b0;
        mux_sel_d   = SEL_NOP;
        write_seg_d = 3'd0;
        read_seg_d  = 3'd0;
        rd_valid_d  = 1'b0;
        rd_owner_d  = rd_owner_q;
        busy_d      = 1'b0;
`ifdef RF_SCHED_RR_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req0 | req1) begin
                    state_d     = ST_ACC;
                    gnt0_d      = ~win1;
                    gnt1_d      = win1;
                    we_d        = win1 ? wr1   : wr0;
                    mux_sel_d   = win1 ? sel1  : sel0;
                    write_seg_d = win1 ? wseg1 : wseg0;
                    read_seg_d  = win1 ? rseg1 : rseg0;
                    busy_d      = 1'b1;
`ifdef RF_SCHED_RR_EN
                    ptr_d       = ~win1;
`endif
                end
            end
            ST_ACC: begin
                if (we_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d    = ST_RDW;
                    rd_valid_d = 1'b1;
                    rd_owner_d = gnt1_q;
                    busy_d     = 1'b1;
                end
            end
            ST_RDW: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; clr aborts any access and restores idle values.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= ST_IDLE;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            we_q        <= 1'b0;
            mux_sel_q   <= SEL_NOP;
            write_seg_q <= 3'd0;
            read_seg_q  <= 3'd0;
            rd_valid_q  <= 1'b0;
            rd_owner_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef RF_SCHED_RR_EN
            ptr_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            we_q        <= we_d;
            mux_sel_q   <= mux_sel_d;
            write_seg_q <= write_seg_d;
            read_seg_q  <= read_seg_d;
            rd_valid_q  <= rd_valid_d;
            rd_owner_q  <= rd_owner_d;
            busy_q      <= busy_d;
`ifdef RF_SCHED_RR_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign we        = we_q;
    assign mux_sel   = mux_sel_q;
    assign write_seg = write_seg_q;
    assign read_seg  = read_seg_q;
    assign rd_valid  = rd_valid_q;
    assign rd_owner  = rd_owner_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_rf_access_sched.sv
// Bench for rf_access_sched: directed steps plus random traffic against a transaction-level model.
// Outputs are compared on the falling edge, inputs change right after the comparison.
// Honours RF_SCHED_RR_EN the same way the design does.
module tb_rf_access_sched;

`ifdef RF_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clr, req0, req1, wr0, wr1;
    logic [2:0] sel0, sel1, wseg0, wseg1, rseg0, rseg1;
    logic       gnt0, gnt1, we, rd_valid, rd_owner, busy;
    logic [2:0] mux_sel, write_seg, read_seg;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rf_access_sched dut (
        .clk(clk), .clr(clr),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .sel0(sel0), .sel1(sel1), .wseg0(wseg0), .wseg1(wseg1),
        .rseg0(rseg0), .rseg1(rseg1),
        .gnt0(gnt0), .gnt1(gnt1), .we(we), .mux_sel(mux_sel),
        .write_seg(write_seg), .read_seg(read_seg),
        .rd_valid(rd_valid), .rd_owner(rd_owner), .busy(busy)
    );

    // Model: a transaction occupies 1 busy cycle (write) or 2 (read); the second
    // cycle of a read delivers data to the winner.
    int         m_left;   // busy cycles still to come, including the current one
    int         m_win;
    bit         m_pref;   // requester that wins a tie under round-robin
    logic       e_gnt0, e_gnt1, e_we, e_rdv, e_own, e_busy;
    logic [2:0] e_mux, e_ws, e_rs;

    task automatic idle_outs();
        e_gnt0 = 0; e_gnt1 = 0; e_we = 0; e_mux = 3'b111;
        e_ws = 0; e_rs = 0; e_rdv = 0; e_busy = 0;
    endtask

    task automatic model_edge();
        if (clr) begin
            m_left = 0; m_pref = 0; e_own = 0;
            idle_outs();
        end else if (m_left == 0) begin
            idle_outs();
            if (req0 || req1) begin
                if (req0 && req1) m_win = RR ? int'(m_pref) : 0;
                else              m_win = req1 ? 1 : 0;
                m_pref = (m_win == 0);
                e_gnt0 = (m_win == 0);
                e_gnt1 = (m_win == 1);
                e_we   = m_win ? wr1   : wr0;
                e_mux  = m_win ? sel1  : sel0;
                e_ws   = m_win ? wseg1 : wseg0;
                e_rs   = m_win ? rseg1 : rseg0;
                e_busy = 1;
                m_left = e_we ? 1 : 2;
            end
        end else begin
            m_left = m_left - 1;
            idle_outs();
            if (m_left > 0) begin
                e_rdv  = 1;
                e_own  = logic'(m_win);
                e_busy = 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("m_gnt0", {2'b0, gnt0}, {2'b0, e_gnt0});
        chk("m_gnt1", {2'b0, gnt1}, {2'b0, e_gnt1});
        chk("m_we", {2'b0, we}, {2'b0, e_we});
        chk("m_mux_sel", mux_sel, e_mux);
        chk("m_write_seg", write_seg, e_ws);
        chk("m_read_seg", read_seg, e_rs);
        chk("m_rd_valid", {2'b0, rd_valid}, {2'b0, e_rdv});
        chk("m_rd_owner", {2'b0, rd_owner}, {2'b0, e_own});
        chk("m_busy", {2'b0, busy}, {2'b0, e_busy});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int ngrant;
        int who;
        clr = 1; req0 = 1; req1 = 0; wr0 = 1; wr1 = 0;
        sel0 = 3'd3; sel1 = 0; wseg0 = 0; wseg1 = 0; rseg0 = 0; rseg1 = 0;
        m_left = 0; m_win = 0; m_pref = 0; e_own = 0;
        idle_outs();

        // Reset held two cycles with a pending request
        step(); step();
        chk("rst_gnt0", {2'b0, gnt0}, 3'd0);
        chk("rst_we", {2'b0, we}, 3'd0);
        chk("rst_mux", mux_sel, 3'b111);
        chk("rst_busy", {2'b0, busy}, 3'd0);
        chk("rst_rdv", {2'b0, rd_valid}, 3'd0);
        req0 = 0; clr = 0;
        step();

        // Single write from requester 0
        req0 = 1; wr0 = 1; sel0 = 3'b011; wseg0 = 3'd5; rseg0 = 3'd1;
        step();
        chk("wr_gnt0", {2'b0, gnt0}, 3'd1);
        chk("wr_we", {2'b0, we}, 3'd1);
        chk("wr_mux", mux_sel, 3'b011);
        chk("wr_wseg", write_seg, 3'd5);
        req0 = 0;
        step();
        chk("wr_busy_after", {2'b0, busy}, 3'd0);

        // Single read from requester 1
        req1 = 1; wr1 = 0; sel1 = 3'b000; rseg1 = 3'd3; wseg1 = 3'd2;
        step();
        chk("rd_gnt1", {2'b0, gnt1}, 3'd1);
        chk("rd_we", {2'b0, we}, 3'd0);
        chk("rd_rseg", read_seg, 3'd3);
        req1 = 0;
        step();
        chk("rd_valid", {2'b0, rd_valid}, 3'd1);
        chk("rd_owner", {2'b0, rd_owner}, 3'd1);
        step();
        chk("rd_valid_drop", {2'b0, rd_valid}, 3'd0);
        chk("rd_owner_hold", {2'b0, rd_owner}, 3'd1);

        // R0<-SP path: write_seg passes through, we for exactly one cycle
        req0 = 1; wr0 = 1; sel0 = 3'b100; wseg0 = 3'd6;
        step();
        chk("r0_mux", mux_sel, 3'b100);
        chk("r0_wseg", write_seg, 3'd6);
        chk("r0_we", {2'b0, we}, 3'd1);
        req0 = 0;
        step();
        chk("r0_we_off", {2'b0, we}, 3'd0);

        // Write with the no-op source still asserts we
        req0 = 1; wr0 = 1; sel0 = 3'b111; wseg0 = 3'd1;
        step();
        chk("nop_we", {2'b0, we}, 3'd1);
        req0 = 0;
        step();

        // Abort: clr during the ACC cycle of a read
        req1 = 1; wr1 = 0; rseg1 = 3'd2;
        step();
        chk("ab_gnt1", {2'b0, gnt1}, 3'd1);
        req1 = 0; clr = 1;
        step();
        chk("ab_rdv", {2'b0, rd_valid}, 3'd0);
        chk("ab_busy", {2'b0, busy}, 3'd0);
        chk("ab_we", {2'b0, we}, 3'd0);
        clr = 0;
        step();

        // Contention: both requesters writing continuously
        req0 = 1; req1 = 1; wr0 = 1; wr1 = 1; sel0 = 3'd2; sel1 = 3'd3;
        ngrant = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (gnt0 || gnt1) begin
                who = gnt1 ? 1 : 0;
                chk("cont_winner", who[2:0], RR ? 3'(ngrant % 2) : 3'd0);
                ngrant++;
            end
        end
        chk("cont_count", ngrant[2:0], 3'd6);
        req0 = 0; req1 = 0;
        step(); step();

        // Random traffic with occasional clears, checked every cycle by the model
        for (int c = 0; c < 400; c++) begin
            clr   = ($urandom_range(0, 31) == 0);
            req0  = $urandom_range(0, 1) == 1;
            req1  = $urandom_range(0, 1) == 1;
            wr0   = $urandom_range(0, 1) == 1;
            wr1   = $urandom_range(0, 1) == 1;
            sel0  = 3'($urandom); sel1  = 3'($urandom);
            wseg0 = 3'($urandom); wseg1 = 3'($urandom);
            rseg0 = 3'($urandom); rseg1 = 3'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
